// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first two's-complement subtractor: diff = a - b over WIDTH cycles.
// Optional signed-overflow output enabled by SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned RW = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [RW-1:0]    res_sr;
    logic             bor;
    logic [CNT_W-1:0] cnt;
    logic             d_c;
    logic             bor_next_c;
    logic             last_c;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Full-subtractor cell and next-state decode
    always_comb begin
        state_next = state;
        d_c        = a_sr[0] ^ b_sr[0] ^ bor;
        bor_next_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);
        last_c     = (cnt == CNT_W'(WIDTH - 1));
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_c) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs; result only lands in diff on the final bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            bor        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        bor  <= 1'b0;
                        cnt  <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= RW'({d_c, res_sr} >> 1);
                    bor    <= bor_next_c;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_c) begin
                        diff       <= {d_c, res_sr};
                        borrow_out <= bor_next_c;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                        overflow   <= (a_msb != b_msb) && (d_c != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first two's-complement subtractor computing a − b over WIDTH clock cycles.
- One full-subtractor cell plus a registered borrow flip-flop; the inverse arithmetic direction of the team's full-adder cells.
- Serves area-constrained datapaths: start/busy/done handshake, result held until the next operation.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- diff  output  WIDTH  a − b mod 2^WIDTH, held after done
- borrow_out  output  1  final borrow; 1 iff unsigned a < b

Behaviour:
- Reset (rst_n=0 at a rising edge of clk):
  - state=IDLE; busy=0, done=0, diff=0, borrow_out=0.
  - Shift registers, borrow flip-flop and counter all cleared.
  - Reset overrides everything, including a RUN in progress; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - Load a_sr←a, b_sr←b, bor←0, cnt←0.
  - → RUN; busy=1 from the next cycle.
- RUN, each edge, using bit0 of a_sr and b_sr:
  - d = a0 ^ b0 ^ bor
  - bor_next = (~a0 & b0) | (~(a0 ^ b0) & bor)
  - a_sr and b_sr shift right one bit; d shifts into the MSB of the result shift register; cnt++.
- RUN exit: on the edge where cnt reaches WIDTH−1 (the WIDTH-th bit is processed):
  - → DONE.
  - diff ← completed result; borrow_out ← bor_next.
- DONE: done=1, busy=0 for exactly one cycle, then → IDLE unconditionally.
- Latency: start accepted at edge E0 → done high in the cycle following edge E_WIDTH (WIDTH cycles). Throughput is one operation per WIDTH+2 cycles.
- diff and borrow_out:
  - Change only on the RUN→DONE edge or on reset.
  - Stable from done through the next completion.
  - Intermediate bits are never visible on diff; the result builds in an internal shift register.
- start while busy=1 or in DONE: ignored, no queuing.
- start held high continuously: a new operation is accepted on every return to IDLE.
- a and b are don't-care except at the accepting edge; changes during RUN have no effect.
- Arithmetic: modulo 2^WIDTH, with no saturation.
  - a=b gives diff=0, borrow_out=0.
  - a=0, b=2^WIDTH−1 gives diff=1, borrow_out=1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVERFLOW_EN.
- Defined:
  - Adds output port `overflow  output  1`: signed two's-complement overflow.
  - overflow = (a_msb ≠ b_msb) & (diff_msb ≠ a_msb), using the operand MSBs captured at start.
  - Updated on the same edge as diff; reset value 0; held alongside diff.
- Undefined:
  - The port, the captured MSB registers and the logic are absent.
  - All other behaviour is identical.

Test Plan (WIDTH=8):
- Reset, then a=0x05, b=0x03, start=1 for one cycle → busy=1 for 8 cycles; done pulses on the 8th cycle after the start edge; diff=0x02, borrow_out=0.
- a=0x03, b=0x05 → diff=0xFE, borrow_out=1. a=0x00, b=0x01 → diff=0xFF, borrow_out=1. a=0x5A, b=0x5A → diff=0x00, borrow_out=0.
- Start 0x10−0x01, pulse start with a=0xFF, b=0x00 at cycle 3 of RUN → second request ignored; diff=0x0F; exactly one done pulse; diff still 0x0F 5 cycles later.
- Start held high; ops 0x20−0x10 then 0x01−0x02 → done pulses 10 cycles apart; diff 0x10 then 0xFF; borrow_out 0 then 1.
- rst_n=0 for one edge at RUN cycle 4 → next cycle busy=0, done=0, diff=0x00, borrow_out=0; no done pulse follows. A new start then completes correctly.
- With SERIAL_SUBTRACTOR_OVERFLOW_EN:
  - 0x80−0x01 → diff=0x7F, borrow_out=0, overflow=1.
  - 0x7F−0xFF → diff=0x80, borrow_out=1, overflow=1.
  - 0x05−0x03 → overflow=0.
- Without the macro: the design compiles with no overflow port.
